// File: rtl/dvp_rx_framer.sv
// dvp_rx_framer: DVP sensor receiver. Samples href/hsync/vsync/data on xclk
// (the sensor pixel clock, so no CDC), strips blanking and emits a registered
// pixel stream with sof/eol/eof markers, plus per-frame geometry status.
//
// Optional build macro DVP_RX_CROP_EN: adds CROP_X/CROP_Y/CROP_W/CROP_H and
// gates the pixel stream to that window. Measurement always uses the full
// (uncropped) geometry.
//
// Ports:
//   xclk, rst_n                  clock, async active-low reset
//   href, hsync, vsync, data     sensor pins (hsync is sampled but unused)
//   out_valid/out_data           pixel strobe and pixel, 2 cycles after sampling
//   out_sof/out_eol/out_eof      frame start / line end / frame end markers
//   frame_done                   one-cycle pulse when a frame completes
//   frame_width/frame_height     last line width and line count of that frame
//   frame_err                    frame geometry error, held until next frame_done
//   frame_cnt/err_cnt            wrapping completed / errored frame counters
module dvp_rx_framer #(
  parameter int BITS   = 8,
  parameter int H_DISP = 1280,
  parameter int V_DISP = 960,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b1
`ifdef DVP_RX_CROP_EN
  ,
  parameter int CROP_X = 0,
  parameter int CROP_Y = 0,
  parameter int CROP_W = H_DISP,
  parameter int CROP_H = V_DISP
`endif
) (
  input  logic            xclk,
  input  logic            rst_n,
  input  logic            href,
  input  logic            hsync,
  input  logic            vsync,
  input  logic [BITS-1:0] data,
  output logic            out_valid,
  output logic [BITS-1:0] out_data,
  output logic            out_sof,
  output logic            out_eol,
  output logic            out_eof,
  output logic            frame_done,
  output logic [15:0]     frame_width,
  output logic [15:0]     frame_height,
  output logic            frame_err,
  output logic [15:0]     frame_cnt,
  output logic [15:0]     err_cnt
);
  typedef struct packed {
    logic            href;
    logic            hsync;
    logic            vsync;
    logic [BITS-1:0] data;
  } smp_t;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_VSYNC  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  smp_t            s1_q, s1_d, s2_q, s2_d;
  logic [1:0]      state_q, state_d;
  logic [15:0]     pix_x_q, pix_x_d, line_y_q, line_y_d, lw_q, lw_d;
  logic            err_q, err_d, sof_pend_q, sof_pend_d;
  logic            out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  logic            out_eol_q, out_eol_d, out_eof_q, out_eof_d;
  logic [BITS-1:0] out_data_q, out_data_d;
  logic            frame_done_q, frame_done_d, frame_err_q, frame_err_d;
  logic [15:0]     frame_width_q, frame_width_d, frame_height_q, frame_height_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;

  logic        vs_act, s2_act, vs_edge, fwd, eol;
  logic        emit, emit_eol, emit_eof;
  logic [16:0] w_cur;
  logic        unused_hs;

  assign vs_act  = (s1_q.vsync == V_POL);
  assign s2_act  = (s2_q.vsync == V_POL);
  assign vs_edge = vs_act && !s2_act;
  // s2 holds the pixel being output; s1 is the next sample, so a low s1.href
  // tells us s2 is the last pixel of its line.
  assign fwd     = s2_q.href && !s2_act && (state_q == S_VSYNC || state_q == S_ACTIVE);
  assign eol     = fwd && !s1_q.href;
  assign w_cur   = {1'b0, pix_x_q} + 17'd1;
  assign unused_hs = s2_q.hsync ^ H_POL;

`ifdef DVP_RX_CROP_EN
  logic [31:0] px32, ly32;
  assign px32 = {16'd0, pix_x_q};
  assign ly32 = {16'd0, line_y_q};
  always_comb begin
    emit     = fwd && (px32 >= 32'(CROP_X)) && (px32 < 32'(CROP_X + CROP_W))
                   && (ly32 >= 32'(CROP_Y)) && (ly32 < 32'(CROP_Y + CROP_H));
    emit_eol = emit && (px32 == 32'(CROP_X + CROP_W - 1));
    emit_eof = emit_eol && (ly32 == 32'(CROP_Y + CROP_H - 1));
  end
`else
  always_comb begin
    emit     = fwd;
    emit_eol = eol;
    emit_eof = eol && ({16'd0, line_y_q} == 32'(V_DISP - 1));
  end
`endif

  always_comb begin
    s1_d           = {href, hsync, vsync, data};
    s2_d           = s1_q;
    state_d        = state_q;
    pix_x_d        = pix_x_q;
    line_y_d       = line_y_q;
    lw_d           = lw_q;
    err_d          = err_q;
    sof_pend_d     = sof_pend_q;
    frame_done_d   = 1'b0;
    frame_width_d  = frame_width_q;
    frame_height_d = frame_height_q;
    frame_err_d    = frame_err_q;
    frame_cnt_d    = frame_cnt_q;
    err_cnt_d      = err_cnt_q;

    out_valid_d = emit;
    out_data_d  = emit ? s2_q.data : '0;
    out_sof_d   = emit && sof_pend_q;
    out_eol_d   = emit_eol;
    out_eof_d   = emit_eof;

    // Geometry counters follow the full line, independent of any crop window.
    if (fwd) begin
      if (eol) begin
        pix_x_d  = '0;
        lw_d     = w_cur[16] ? 16'hFFFF : w_cur[15:0];
        line_y_d = (line_y_q == 16'hFFFF) ? line_y_q : line_y_q + 16'd1;
        if (w_cur != 17'(H_DISP)) err_d = 1'b1;
      end else begin
        pix_x_d  = (pix_x_q == 16'hFFFF) ? pix_x_q : pix_x_q + 16'd1;
      end
    end
    if (emit) sof_pend_d = 1'b0;

    case (state_q)
      S_IDLE: if (vs_edge) state_d = S_VSYNC;
      S_VSYNC: begin
        pix_x_d    = '0;
        line_y_d   = '0;
        lw_d       = '0;
        err_d      = 1'b0;
        sof_pend_d = 1'b1;
        if (s1_q.href && !vs_act) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        // href during vsync: that pixel is dropped (s2_act gates it) and the
        // frame is flagged; this also catches a line cut short by vsync.
        if (s1_q.href && vs_act) err_d = 1'b1;
        if (vs_edge) begin
          state_d        = S_VSYNC;
          frame_done_d   = 1'b1;
          frame_width_d  = lw_d;
          frame_height_d = line_y_d;
          frame_err_d    = err_d || ({16'd0, line_y_d} != 32'(V_DISP));
          frame_cnt_d    = frame_cnt_q + 16'd1;
          if (frame_err_d) err_cnt_d = err_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q           <= '0;
      s2_q           <= '0;
      state_q        <= S_IDLE;
      pix_x_q        <= '0;
      line_y_q       <= '0;
      lw_q           <= '0;
      err_q          <= 1'b0;
      sof_pend_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_sof_q      <= 1'b0;
      out_eol_q      <= 1'b0;
      out_eof_q      <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_width_q  <= '0;
      frame_height_q <= '0;
      frame_err_q    <= 1'b0;
      frame_cnt_q    <= '0;
      err_cnt_q      <= '0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      state_q        <= state_d;
      pix_x_q        <= pix_x_d;
      line_y_q       <= line_y_d;
      lw_q           <= lw_d;
      err_q          <= err_d;
      sof_pend_q     <= sof_pend_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_sof_q      <= out_sof_d;
      out_eol_q      <= out_eol_d;
      out_eof_q      <= out_eof_d;
      frame_done_q   <= frame_done_d;
      frame_width_q  <= frame_width_d;
      frame_height_q <= frame_height_d;
      frame_err_q    <= frame_err_d;
      frame_cnt_q    <= frame_cnt_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_sof      = out_sof_q;
  assign out_eol      = out_eol_q;
  assign out_eof      = out_eof_q;
  assign frame_done   = frame_done_q;
  assign frame_width  = frame_width_q;
  assign frame_height = frame_height_q;
  assign frame_err    = frame_err_q;
  assign frame_cnt    = frame_cnt_q;
  assign err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_dvp_rx_framer.sv
// Testbench for dvp_rx_framer: 8x4 instance driven by table frames, corner
// sequences and random frames against a frame-level model; 1x1 instance for
// the latency check.
module tb_dvp_rx_framer;
  localparam int BITS = 8;
  localparam int H = 8;
  localparam int V = 4;
`ifdef DVP_RX_CROP_EN
  localparam bit CROP = 1'b1;
`else
  localparam bit CROP = 1'b0;
`endif
  localparam int CX = 2, CY = 1, CW = 4, CH = 2;

  logic xclk = 1'b0;
  always #5 xclk = ~xclk;

  logic rst_n, href, hsync, vsync;
  logic [BITS-1:0] data, out_data;
  logic out_valid, out_sof, out_eol, out_eof, frame_done, frame_err;
  logic [15:0] frame_width, frame_height, frame_cnt, err_cnt;

  logic href1, hsync1, vsync1;
  logic [BITS-1:0] data1, out_data1;
  logic out_valid1, out_sof1, out_eol1, out_eof1, frame_done1, frame_err1;
  logic [15:0] frame_width1, frame_height1, frame_cnt1, err_cnt1;

  dvp_rx_framer #(.BITS(BITS), .H_DISP(H), .V_DISP(V), .H_POL(1'b0), .V_POL(1'b1)
`ifdef DVP_RX_CROP_EN
    , .CROP_X(CX), .CROP_Y(CY), .CROP_W(CW), .CROP_H(CH)
`endif
  ) dut (
    .xclk(xclk), .rst_n(rst_n), .href(href), .hsync(hsync), .vsync(vsync), .data(data),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
    .out_eof(out_eof), .frame_done(frame_done), .frame_width(frame_width),
    .frame_height(frame_height), .frame_err(frame_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  dvp_rx_framer #(.BITS(BITS), .H_DISP(1), .V_DISP(1), .H_POL(1'b0), .V_POL(1'b1)) dut1 (
    .xclk(xclk), .rst_n(rst_n), .href(href1), .hsync(hsync1), .vsync(vsync1), .data(data1),
    .out_valid(out_valid1), .out_data(out_data1), .out_sof(out_sof1), .out_eol(out_eol1),
    .out_eof(out_eof1), .frame_done(frame_done1), .frame_width(frame_width1),
    .frame_height(frame_height1), .frame_err(frame_err1), .frame_cnt(frame_cnt1), .err_cnt(err_cnt1)
  );

  typedef struct packed { logic [BITS-1:0] d; logic sof, eol, eof; } exp_t;
  typedef struct packed { logic [15:0] w, h; logic e; logic [15:0] fc, ec; } st_t;
  typedef struct { int nl; int si; int sw; int ow; int oh; bit oe; } vec_t;

  exp_t pix_q[$];
  st_t  st_q[$];
  int   n_chk = 0, n_fail = 0;

  // frame-level model state
  bit   armed = 1'b0, sof_seen = 1'b0, ferr = 1'b0;
  int   n_lines = 0, last_w = 0;
  logic [15:0] exp_fc = '0, exp_ec = '0;
  logic [BITS-1:0] dcnt = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bad(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event (t=%0t)", nm, $time);
  endtask

  task automatic step(input logic h, input logic v, input logic [BITS-1:0] d);
    href = h; vsync = v; data = d;
    @(posedge xclk); #1;
  endtask

  task automatic step1(input logic h, input logic v, input logic [BITS-1:0] d);
    href1 = h; vsync1 = v; data1 = d;
    @(posedge xclk); #1;
  endtask

  // Expected output for pixel j of line i (line width w) in the current frame.
  task automatic push_pix(input int i, input int j, input int w, input logic [BITS-1:0] d);
    exp_t e;
    bit in_w;
    e = '0;
    if (CROP) begin
      in_w  = (j >= CX) && (j < CX + CW) && (i >= CY) && (i < CY + CH);
      e.eol = (j == CX + CW - 1);
      e.eof = e.eol && (i == CY + CH - 1);
    end else begin
      in_w  = 1'b1;
      e.eol = (j == w - 1);
      e.eof = e.eol && (i == V - 1);
    end
    if (in_w) begin
      e.d = d;
      e.sof = !sof_seen;
      sof_seen = 1'b1;
      pix_q.push_back(e);
    end
  endtask

  // Vsync pulse: closes the current frame (if one was received) and opens the next.
  // hcyc cycles of href are driven inside the pulse (dropped pixels).
  task automatic do_vsync(input int len, input int hcyc, input bit ovr,
                          input int ow, input int oh, input bit oe);
    st_t s;
    bit e;
    if (armed && n_lines > 0) begin
      if (ovr) begin
        s.w = 16'(ow); s.h = 16'(oh); e = oe;
      end else begin
        s.w = 16'(last_w); s.h = 16'(n_lines); e = ferr || (n_lines != V);
      end
      exp_fc++;
      if (e) exp_ec++;
      s.e = e; s.fc = exp_fc; s.ec = exp_ec;
      st_q.push_back(s);
    end
    armed = 1'b1; n_lines = 0; last_w = 0; ferr = 1'b0; sof_seen = 1'b0; dcnt = '0;
    for (int k = 0; k < len; k++) step(k < hcyc, 1'b1, '0);
    step(1'b0, 1'b0, '0);
  endtask

  task automatic do_line(input int w, input int gap);
    for (int j = 0; j < w; j++) begin
      if (armed) push_pix(n_lines, j, w, dcnt);
      step(1'b1, 1'b0, dcnt);
      dcnt++;
    end
    if (armed) begin
      last_w = w;
      if (w != H) ferr = 1'b1;
    end
    n_lines++;
    repeat (gap) step(1'b0, 1'b0, '0);
  endtask

  // Output monitor / scoreboard for the 8x4 instance.
  always @(negedge xclk) begin
    exp_t e;
    st_t s;
    if (!rst_n) begin
      chk("rst_outputs", {out_valid, out_data, out_sof, out_eol, out_eof, frame_done,
                          frame_width, frame_height, frame_err, frame_cnt, err_cnt}, '0);
    end else begin
      if (out_valid) begin
        if (pix_q.size() == 0) bad("extra_pixel");
        else begin
          e = pix_q.pop_front();
          chk("pixel", {out_data, out_sof, out_eol, out_eof}, {e.d, e.sof, e.eol, e.eof});
        end
      end else if (out_sof || out_eol || out_eof) bad("marker_without_valid");
      if (frame_done) begin
        if (st_q.size() == 0) bad("extra_frame_done");
        else begin
          s = st_q.pop_front();
          chk("frame_status", {frame_width, frame_height, frame_err, frame_cnt, err_cnt},
              {s.w, s.h, s.e, s.fc, s.ec});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[6];
    int   nl, w;
    tab[0] = '{4, -1, 8, 8, 4, 1'b0};  // clean
    tab[1] = '{4, -1, 8, 8, 4, 1'b0};  // clean
    tab[2] = '{4,  2, 7, 8, 4, 1'b1};  // line 2 short
    tab[3] = '{5, -1, 8, 8, 5, 1'b1};  // one extra line
    tab[4] = '{4,  3, 9, 9, 4, 1'b1};  // last line long
    tab[5] = '{3, -1, 8, 8, 3, 1'b1};  // one line missing

    rst_n = 1'b0; href = 0; hsync = 0; vsync = 0; data = '0;
    href1 = 0; hsync1 = 0; vsync1 = 0; data1 = '0;
    repeat (3) step(1'b0, 1'b0, '0);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0, '0);
    chk("reset_state", {out_valid, out_data, out_sof, out_eol, out_eof, frame_done,
                        frame_width, frame_height, frame_err, frame_cnt, err_cnt}, '0);
    chk("reset_state1", {out_valid1, out_data1, frame_done1, frame_cnt1, err_cnt1}, '0);

    // Latency on the 1x1 instance: sample at edge k, visible after edge k+2.
    step1(1'b0, 1'b1, '0);
    step1(1'b0, 1'b0, '0);
    step1(1'b0, 1'b0, '0);
    step1(1'b1, 1'b0, 8'hA5);
    chk("lat_edge_k", out_valid1, 1'b0);
    step1(1'b0, 1'b0, '0);
    chk("lat_edge_k1", out_valid1, 1'b0);
    step1(1'b0, 1'b0, '0);
    chk("lat_edge_k2", {out_valid1, out_data1, out_sof1, out_eol1, out_eof1},
        {1'b1, 8'hA5, 1'b1, 1'b1, 1'b1});
    step1(1'b0, 1'b0, '0);
    chk("lat_edge_k3", out_valid1, 1'b0);
    step1(1'b0, 1'b1, '0);
    begin
      int t = 0;
      while (!frame_done1 && t < 8) begin step1(1'b0, 1'b0, '0); t++; end
      chk("lat_frame_done_seen", frame_done1, 1'b1);
      chk("lat_frame_status", {frame_width1, frame_height1, frame_err1, frame_cnt1, err_cnt1},
          {16'd1, 16'd1, 1'b0, 16'd1, 16'd0});
    end

    // Table frames on the 8x4 instance.
    do_vsync(2, 0, 1'b0, 0, 0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < tab[r].nl; i++) do_line((i == tab[r].si) ? tab[r].sw : H, 3);
      do_vsync(2, 0, 1'b1, tab[r].ow, tab[r].oh, tab[r].oe);
    end

    // Line cut by vsync while href is high: 3 full lines, then 5 pixels.
    for (int i = 0; i < 3; i++) do_line(H, 2);
    for (int j = 0; j < 5; j++) begin
      push_pix(3, j, 1000, dcnt);
      step(1'b1, 1'b0, dcnt);
      dcnt++;
    end
    do_vsync(4, 3, 1'b1, 8, 3, 1'b1);

    // Random frames against the model.
    for (int f = 0; f < 8; f++) begin
      nl = int'($urandom_range(3, 5));
      for (int i = 0; i < nl; i++) begin
        w = ($urandom_range(0, 9) < 7) ? H : int'($urandom_range(6, 10));
        do_line(w, int'($urandom_range(1, 4)));
      end
      do_vsync(int'($urandom_range(1, 3)), 0, 1'b0, 0, 0, 1'b0);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, '0);
    end

    // Reset during line 2, then a clean frame.
    do_line(H, 2);
    do_line(H, 2);
    for (int j = 0; j < 3; j++) begin
      push_pix(2, j, H, dcnt);
      step(1'b1, 1'b0, dcnt);
      dcnt++;
    end
    rst_n = 1'b0;
    pix_q.delete(); st_q.delete();
    armed = 1'b0; exp_fc = '0; exp_ec = '0;
    #1;
    chk("rst_async", {out_valid, out_data, out_sof, out_eol, out_eof, frame_done,
                      frame_width, frame_height, frame_err, frame_cnt, err_cnt}, '0);
    for (int j = 0; j < 3; j++) begin step(1'b1, 1'b0, dcnt); dcnt++; end
    rst_n = 1'b1;
    for (int j = 0; j < 2; j++) begin step(1'b1, 1'b0, dcnt); dcnt++; end
    repeat (2) step(1'b0, 1'b0, '0);
    do_line(H, 2);
    do_vsync(2, 0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < V; i++) do_line(H, 2);
    do_vsync(2, 0, 1'b1, 8, 4, 1'b0);

    repeat (10) step(1'b0, 1'b0, '0);
    chk("pixels_drained", pix_q.size(), 0);
    chk("frames_drained", st_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
